// File: rtl/add_share_arb_pkg.sv
// Shared types and constants for the two-requester shared adder.
package add_share_arb_pkg;

    localparam int ASA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } asa_state_t;

endpackage

// File: rtl/add_share_arb_fa.sv
// Dataflow full adder: {o_cout, o_sum} = i_a + i_b + i_cin, carry kept.
module add_share_arb_fa
    import add_share_arb_pkg::*;
#(
    parameter int WIDTH = ASA_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_full;

    // Widen every operand by one bit so the carry-out is never truncated.
    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_cout = w_full[WIDTH];

endmodule

// File: rtl/add_share_arb.sv
// Two requesters share one adder through a round-robin arbiter.
// Each requester owns a carry register usable as carry-in for chained adds.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate; req_ready shows the winner, accept latches operands
// EXEC    | adder evaluates latched operands; result registered
// RESP    | rsp_valid high, result held until rsp_ready; carry stored
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int WIDTH = ASA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_In1,
    input  logic [2*WIDTH-1:0] req_In2,
    input  logic [1:0]         req_Cin,
    input  logic [1:0]         req_chain,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_Sum,
    output logic               rsp_Cout
);

    asa_state_t       r_state;
    asa_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic             r_cin;
    logic             r_id;
    logic             r_last_grant;
    logic [1:0]       r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [1:0]       w_grant;
    logic             w_win;
    logic             w_accept;
    logic             w_cin_eff;
    logic [WIDTH-1:0] w_in1_sel;
    logic [WIDTH-1:0] w_in2_sel;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Round-robin pick among valid requesters; only offered in IDLE out of reset.
    always_comb begin
        w_grant = 2'b00;
        w_win   = 1'b0;
        if (rst_n && (r_state == ST_IDLE)) begin
            unique case (req_valid)
                2'b01: begin
                    w_win   = 1'b0;
                    w_grant = 2'b01;
                end
                2'b10: begin
                    w_win   = 1'b1;
                    w_grant = 2'b10;
                end
                2'b11: begin
                    w_win   = ~r_last_grant;
                    w_grant = r_last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    w_win   = 1'b0;
                    w_grant = 2'b00;
                end
            endcase
        end
    end

    assign w_accept  = |w_grant;
    assign w_in1_sel = w_win ? req_In1[2*WIDTH-1:WIDTH] : req_In1[WIDTH-1:0];
    assign w_in2_sel = w_win ? req_In2[2*WIDTH-1:WIDTH] : req_In2[WIDTH-1:0];
    assign w_cin_eff = req_chain[w_win] ? r_carry[w_win] : req_Cin[w_win];

    add_share_arb_fa #(
        .WIDTH (WIDTH)
    ) u_fa (
        .i_a    (r_in1),
        .i_b    (r_in2),
        .i_cin  (r_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one operation in flight, response held under backpressure.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_EXEC;
            ST_EXEC:                w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on accept, result capture in EXEC, carry write on handoff.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in1        <= '0;
            r_in2        <= '0;
            r_cin        <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_carry      <= 2'b00;
            r_sum        <= '0;
            r_cout       <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_accept) begin
                r_in1        <= w_in1_sel;
                r_in2        <= w_in2_sel;
                r_cin        <= w_cin_eff;
                r_id         <= w_win;
                r_last_grant <= w_win;
            end
            if (r_state == ST_EXEC) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_carry[r_id] <= r_cout;
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_Sum   = r_sum;
    assign rsp_Cout  = r_cout;

endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb: basic add, chaining, fairness,
// backpressure and reset during an operation.
module tb_add_share_arb;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_In1;
    logic [2*W-1:0] req_In2;
    logic [1:0]    req_Cin;
    logic [1:0]    req_chain;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [W-1:0]  rsp_Sum;
    logic          rsp_Cout;

    int n_checks = 0;
    int n_errors = 0;

    add_share_arb #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_In1   (req_In1),
        .req_In2   (req_In2),
        .req_Cin   (req_Cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_Sum   (rsp_Sum),
        .rsp_Cout  (rsp_Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic chain);
        req_In1[id*W +: W] = a;
        req_In2[id*W +: W] = b;
        req_Cin[id]        = cin;
        req_chain[id]      = chain;
    endtask

    // One full operation from IDLE with rsp_ready high; checks every cycle.
    task automatic do_op(input string tag, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic chain,
                         input logic [W-1:0] exp_sum, input logic exp_cout);
        logic [1:0] onehot;
        onehot = (id == 1) ? 2'b10 : 2'b01;
        set_req(id, a, b, cin, chain);
        req_valid = onehot;
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(onehot));
        tick();
        req_valid = 2'b00;
        #1;
        chk({tag, ".exec_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".exec_ready"}, 64'(req_ready), 64'd0);
        tick();
        chk({tag, ".resp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".sum"}, 64'(rsp_Sum), 64'(exp_sum));
        chk({tag, ".cout"}, 64'(rsp_Cout), 64'(exp_cout));
        chk({tag, ".id"}, 64'(rsp_id), 64'(id));
        tick();
        chk({tag, ".done"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_In1   = '0;
        req_In2   = '0;
        req_Cin   = 2'b00;
        req_chain = 2'b00;
        rsp_ready = 1'b0;

        // Reset values, and no grant while reset is held.
        tick();
        req_valid = 2'b11;
        tick();
        chk("rst.valid", 64'(rsp_valid), 64'd0);
        chk("rst.sum", 64'(rsp_Sum), 64'd0);
        chk("rst.cout", 64'(rsp_Cout), 64'd0);
        chk("rst.id", 64'(rsp_id), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // Basic add with carry-out, then chaining.
        do_op("basic", 0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b1);
        do_op("chain0", 0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
        do_op("chain1", 1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0000, 1'b0);

        // Fairness from reset: tie held for four operations.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 32'd1, 32'd1, 1'b0, 1'b0);
        set_req(1, 32'd10, 32'd20, 1'b0, 1'b0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr.grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk("rr.exec_ready", 64'(req_ready), 64'd0);
            tick();
            chk("rr.resp_ready", 64'(req_ready), 64'd0);
            chk("rr.id", 64'(rsp_id), 64'(k % 2));
            chk("rr.sum", 64'(rsp_Sum), (k % 2 == 0) ? 64'd2 : 64'd30);
            tick();
        end
        req_valid = 2'b00;

        // Backpressure: 0xFFFFFFFF + 1 held for 10 cycles, others kept waiting.
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        chk("bp.grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b11;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp.valid", 64'(rsp_valid), 64'd1);
            chk("bp.sum", 64'(rsp_Sum), 64'd0);
            chk("bp.cout", 64'(rsp_Cout), 64'd1);
            chk("bp.ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp.handoff", 64'(rsp_valid), 64'd0);
        chk("bp.next_grant", 64'(req_ready), 64'd2);
        req_valid = 2'b00;

        // Reset during EXEC after a req1 accept: result dropped, carries cleared.
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        req_valid = 2'b10;
        #1;
        chk("rm.grant", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rm.valid0", 64'(rsp_valid), 64'd0);
        tick();
        chk("rm.valid1", 64'(rsp_valid), 64'd0);
        req_valid = 2'b11;
        #1;
        chk("rm.tie", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        do_op("rm.carry0", 0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        do_op("rm.carry1", 1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add_share_arb.md
ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 2, one request-valid bit per requester (bit i = requester i).
REQ-005 SHALL have port req_ready, output, 2, the grant/accept bit per requester.
REQ-006 SHALL have port req_In1, input, 2*WIDTH, operand A; requester i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-007 SHALL have port req_In2, input, 2*WIDTH, operand B, packed the same way as req_In1.
REQ-008 SHALL have port req_Cin, input, 2, explicit carry-in per requester.
REQ-009 SHALL have port req_chain, input, 2; when 1, the requester's stored carry replaces req_Cin.
REQ-010 SHALL have port rsp_valid, output, 1, result valid.
REQ-011 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port rsp_id, output, 1, the requester that owns the result.
REQ-013 SHALL have port rsp_Sum, output, WIDTH, the registered sum.
REQ-014 SHALL have port rsp_Cout, output, 1, the registered carry-out.

Function
REQ-015 SHALL run an FSM with states IDLE, EXEC and RESP; exactly one operation is in flight at a time.
REQ-016 SHALL in IDLE assert req_ready[i] combinationally for at most one i, the arbitration winner among the set req_valid bits; req_ready SHALL be 0 in EXEC and RESP.
REQ-017 SHALL arbitrate round-robin:
- If both requesters are valid, grant the one not granted last.
- A lone valid requester always wins.
- last_grant SHALL reset so that requester 0 wins the first tie.
REQ-018 SHALL, on acceptance (req_valid[i] and req_ready[i] in IDLE), in that edge:
- latch In1, In2 and the effective carry-in;
- latch the id, and update last_grant to i;
- move to EXEC.
REQ-019 SHALL use as the effective carry-in carry_q[i] when req_chain[i] is 1, otherwise req_Cin[i].
REQ-020 SHALL in EXEC compute {Cout, Sum} = In1 + In2 + cin at WIDTH+1 bits (no truncation of the carry), register the result, and move to RESP.
REQ-021 SHALL hold rsp_valid high in RESP only, keeping rsp_Sum, rsp_Cout and rsp_id stable until rsp_ready is sampled high.
REQ-022 SHALL, on rsp_valid and rsp_ready, write carry_q[rsp_id] = rsp_Cout and return to IDLE; the next grant is possible in the cycle after the handoff.
REQ-023 SHALL give a latency of 2 cycles from the acceptance edge to rsp_valid, so throughput is at most 1 operation per 3 cycles with rsp_ready tied high.
REQ-024 SHALL ignore requester inputs while in EXEC or RESP; a requester holds req_valid and its operands until it is accepted.
REQ-025 SHALL leave carry_q of a requester unchanged by operations of the other requester.
REQ-026 SHALL hold state while rsp_ready is low indefinitely, with no loss of the result and no new grant.

Reset
REQ-027 SHALL, when rst_n is low at a clock edge, set:
- state = IDLE;
- rsp_valid = 0, rsp_Sum = 0, rsp_Cout = 0, rsp_id = 0;
- carry_q = 2'b00;
- last_grant = 1.
REQ-028 SHALL, on a reset asserted mid-operation (EXEC or RESP), discard the in-flight result with no response and no carry_q update.
REQ-029 SHALL drive req_ready = 0 while rst_n is low.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE/EXEC/RESP) and the default WIDTH constant in the shared package.
REQ-031 SHALL instantiate the existing 32-bit dataflow full adder as the single sub-module for the EXEC computation; the arbiter and FSM stay in add_share_arb.

Verification
REQ-032 SHALL cover a basic add with carry-out:
- Stimulus: req0 with In1 = 0x80000001, In2 = 0x80000001, Cin = 0, chain = 0.
- Response: rsp_valid 2 cycles after accept, rsp_Sum = 0x00000002, rsp_Cout = 1, rsp_id = 0.
REQ-033 SHALL cover chaining:
- Stimulus: the REQ-032 operation, then req0 with In1 = 0, In2 = 0, chain = 1, Cin = 0.
- Response: rsp_Sum = 0x00000001, rsp_Cout = 0.
- Stimulus: then req1 with chain = 1 and In1 = In2 = 0.
- Response: rsp_Sum = 0 (req1's carry_q is still 0).
REQ-034 SHALL cover arbitration fairness:
- Stimulus: req_valid = 2'b11 held for 4 operations from reset.
- Response: grants in the order 0, 1, 0, 1; req_ready is one-hot or zero every cycle.
REQ-035 SHALL cover backpressure:
- Stimulus: rsp_ready = 0 for 10 cycles in RESP, with 0xFFFFFFFF + 0x00000001 as operands.
- Response: rsp_Sum = 0x00000000 and rsp_Cout = 1 stable throughout; req_ready = 0; handoff on the first rsp_ready = 1.
REQ-036 SHALL cover reset mid-operation:
- Stimulus: rst_n low for 1 cycle during EXEC after a req1 accept.
- Response: no rsp_valid; carry_q = 0; the next tie is granted to requester 0.
